// File: rtl/instr_seq_ctrl.sv
// Instruction sequencer: FETCH/DECODE/DELAY/NEXT loop with flag-conditional
// branches, HALT with resume, and a fixed per-instruction execution window.
//
// state   | meaning
// IDLE    | first cycle after reset release
// FETCH   | latch inst_in into ir
// DECODE  | exec_en strobe for ALU/move ops, clear delay counter
// DELAY   | wait EXEC_CYCLES cycles for the datapath
// NEXT    | resolve branch/halt, update pc
// HALT    | parked until resume
module instr_seq_ctrl #(
  parameter int PC_W        = 8,
  parameter int EXEC_CYCLES = 4
) (
  input  logic            clock,
  input  logic            system_reset,
  input  logic [31:0]     inst_in,
  input  logic            carry,
  input  logic            zero,
  input  logic            sign,
  input  logic            overflow,
  input  logic            resume,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     ir,
  output logic            exec_en,
  output logic            halted,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_DELAY  = 3'd3,
    S_NEXT   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] DLY_LAST = 4'(EXEC_CYCLES - 1);
  localparam logic [4:0] OP_JMP   = 5'd12;
  localparam logic [4:0] OP_HLT   = 5'd21;

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [31:0]     ir_q;
  logic            exec_en_q;
  logic            halted_q;
  logic [3:0]      dly_q;
  logic [4:0]      op;
  logic            taken;

  assign op = ir_q[31:27];

  always_comb begin
    taken = 1'b0;
    case (op)
      5'd12:   taken = 1'b1;
      5'd13:   taken = carry;
      5'd14:   taken = !carry;
      5'd15:   taken = sign;
      5'd16:   taken = !sign;
      5'd17:   taken = zero;
      5'd18:   taken = !zero;
      5'd19:   taken = overflow;
      5'd20:   taken = !overflow;
      default: taken = 1'b0;
    endcase
  end

  // Branch targets take only the low PC_W bits; sequential flow wraps.
  always_comb begin
    pc_d = pc_q + 1'b1;
    if (taken) pc_d = ir_q[PC_W-1:0];
  end

  always_ff @(posedge clock or negedge system_reset) begin
    if (!system_reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      exec_en_q <= 1'b0;
      halted_q  <= 1'b0;
      dly_q     <= '0;
    end else begin
      exec_en_q <= 1'b0;
      case (state_q)
        S_IDLE: state_q <= S_FETCH;
        S_FETCH: begin
          // exec_en is registered, so decode the opcode as it is latched.
          ir_q      <= inst_in;
          exec_en_q <= (inst_in[31:27] < OP_JMP);
          state_q   <= S_DECODE;
        end
        S_DECODE: begin
          dly_q   <= '0;
          state_q <= S_DELAY;
        end
        S_DELAY: begin
          if (dly_q == DLY_LAST) state_q <= S_NEXT;
          else                   dly_q   <= dly_q + 1'b1;
        end
        S_NEXT: begin
          if (op == OP_HLT) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            pc_q    <= pc_d;
            state_q <= S_FETCH;
          end
        end
        S_HALT: begin
          if (resume) begin
            pc_q     <= pc_q + 1'b1;
            halted_q <= 1'b0;
            state_q  <= S_FETCH;
          end
        end
        default: begin
          halted_q <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign pc      = pc_q;
  assign ir      = ir_q;
  assign exec_en = exec_en_q;
  assign halted  = halted_q;
  assign state   = state_q;

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Random-program bench for instr_seq_ctrl, checked per instruction against a
// transaction-level model of pc flow, timing, strobes and halt behaviour.
module tb_instr_seq_ctrl;
  localparam int PC_W = 8;
  localparam int EC   = 4;

  logic            clock = 1'b0;
  logic            system_reset = 1'b0;
  logic [31:0]     inst_in, inst_in1;
  logic            carry = 1'b0, zero = 1'b0, sign = 1'b0, overflow = 1'b0, resume = 1'b0;
  logic [PC_W-1:0] pc, pc1;
  logic [31:0]     ir, ir1;
  logic            exec_en, exec_en1, halted, halted1;
  logic [2:0]      state, state1;

  logic [31:0] mem  [256];
  logic [31:0] mem1 [256];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  int              mpc = 0;
  int              last_cyc = 0;
  bit              have_last = 0;
  bit              force_zero = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  assign inst_in  = mem[pc];
  assign inst_in1 = mem1[pc1];

  instr_seq_ctrl #(.PC_W(PC_W), .EXEC_CYCLES(EC)) u_dut (
    .clock(clock), .system_reset(system_reset), .inst_in(inst_in),
    .carry(carry), .zero(zero), .sign(sign), .overflow(overflow), .resume(resume),
    .pc(pc), .ir(ir), .exec_en(exec_en), .halted(halted), .state(state));

  instr_seq_ctrl #(.PC_W(PC_W), .EXEC_CYCLES(1)) u_dut1 (
    .clock(clock), .system_reset(system_reset), .inst_in(inst_in1),
    .carry(carry), .zero(zero), .sign(sign), .overflow(overflow), .resume(1'b0),
    .pc(pc1), .ir(ir1), .exec_en(exec_en1), .halted(halted1), .state(state1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"},   32'(state),   32'd0);
    chk({tag, "_pc"},      32'(pc),      32'd0);
    chk({tag, "_ir"},      ir,           32'd0);
    chk({tag, "_exec_en"}, 32'(exec_en), 32'd0);
    chk({tag, "_halted"},  32'(halted),  32'd0);
  endtask

  task automatic wait_fetch();
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (state == 3'd1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("fetch_timeout", 32'd0, 32'd1);
  endtask

  function automatic bit branch_taken(input int op, input bit c, input bit z, input bit s, input bit v);
    case (op)
      12: return 1'b1;
      13: return c;
      14: return !c;
      15: return s;
      16: return !s;
      17: return z;
      18: return !z;
      19: return v;
      20: return !v;
      default: return 1'b0;
    endcase
  endfunction

  // Entered and left on the negedge of a FETCH cycle.
  task automatic one_instr();
    logic [31:0] word;
    int          op;
    int          nexec;
    int          nwait;
    chk("fetch_state", 32'(state), 32'd1);
    chk("fetch_pc", 32'(pc), 32'(mpc));
    if (have_last) chk("fetch_gap", 32'(cyc - last_cyc), 32'(EC + 3));
    last_cyc  = cyc;
    have_last = 1;
    word = mem[mpc];
    op   = int'(word[31:27]);
    carry    = 1'($urandom);
    zero     = (mpc == 3) ? force_zero : 1'($urandom);
    sign     = 1'($urandom);
    overflow = 1'($urandom);

    @(negedge clock);
    chk("decode_state", 32'(state), 32'd2);
    chk("decode_ir", ir, word);
    chk("decode_exec_en", 32'(exec_en), 32'(op < 12));
    chk("decode_halted", 32'(halted), 32'd0);

    nexec = 0;
    for (int i = 0; i < EC; i++) begin
      resume = 1'($urandom);
      @(negedge clock);
      if (state != 3'd3) chk("delay_state", 32'(state), 32'd3);
      nexec += int'(exec_en);
    end
    resume = 1'($urandom);
    @(negedge clock);
    chk("next_state", 32'(state), 32'd4);
    nexec += int'(exec_en);
    chk("exec_en_outside_decode", 32'(nexec), 32'd0);

    if (op == 21) begin
      resume = 1'b1;
      @(negedge clock);
      resume = 1'b0;
      chk("halt_state", 32'(state), 32'd5);
      chk("halt_halted", 32'(halted), 32'd1);
      nwait = (mpc == 5) ? 10 : int'($urandom_range(1, 6));
      repeat (nwait) @(negedge clock);
      chk("halt_hold_pc", 32'(pc), 32'(mpc));
      chk("halt_hold_halted", 32'(halted), 32'd1);
      chk("halt_exec_en", 32'(exec_en), 32'd0);
      resume = 1'b1;
      @(negedge clock);
      resume = 1'b0;
      chk("resume_halted", 32'(halted), 32'd0);
      mpc = (mpc + 1) % 256;
      have_last = 0;
    end else begin
      resume = 1'b0;
      if (branch_taken(op, carry, zero, sign, overflow)) mpc = int'(word[PC_W-1:0]);
      else                                               mpc = (mpc + 1) % 256;
      @(negedge clock);
    end
  endtask

  initial begin
    int pulses[$];
    for (int i = 0; i < 256; i++) begin
      mem[i]  = $urandom;
      mem1[i] = {5'd2, 27'($urandom)};
    end
    mem[0]    = {5'd2, 27'($urandom)};
    mem[1]    = {5'd2, 27'($urandom)};
    mem[2]    = {5'd2, 27'($urandom)};
    mem[3]    = {5'd17, 19'($urandom), 8'h20};
    mem[4]    = {5'd22, 27'($urandom)};
    mem[5]    = {5'd21, 27'($urandom)};
    mem[6]    = {5'd12, 19'($urandom), 8'hFF};
    mem[8'hFF] = {5'd1, 27'($urandom)};

    #1;
    chk_reset_vals("por");
    repeat (2) @(negedge clock);
    system_reset = 1'b1;

    // EXEC_CYCLES=1 instance: ADD stream, strobes every 4 cycles.
    for (int i = 0; i < 60 && pulses.size() < 4; i++) begin
      @(negedge clock);
      if (exec_en1) pulses.push_back(cyc);
    end
    chk("ec1_pulse_count", 32'(pulses.size()), 32'd4);
    for (int i = 1; i < pulses.size(); i++)
      chk("ec1_gap", 32'(pulses[i] - pulses[i-1]), 32'd4);

    @(negedge clock);
    system_reset = 1'b0;
    #1;
    chk_reset_vals("rst");
    @(negedge clock);
    system_reset = 1'b1;
    wait_fetch();
    mpc = 0;
    have_last = 0;
    force_zero = 1'b1;
    for (int n = 0; n < 120; n++) one_instr();

    // Abort mid-DELAY; outputs clear before the next edge.
    repeat (4) @(negedge clock);
    chk("mid_delay_state", 32'(state), 32'd3);
    #2;
    system_reset = 1'b0;
    #1;
    chk_reset_vals("mid_delay_rst");
    @(negedge clock);
    chk("mid_delay_rst_held_exec_en", 32'(exec_en), 32'd0);
    system_reset = 1'b1;
    wait_fetch();
    chk("first_fetch_pc", 32'(pc), 32'd0);
    mpc = 0;
    have_last = 0;
    force_zero = 1'b0;
    for (int n = 0; n < 120; n++) one_instr();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
